// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, writer state encoding and shift-add helper.
package sprite_pkg;

    localparam int DEF_SPR_W  = 5;
    localparam int DEF_SPR_H  = 5;
    localparam int DEF_GLYPHS = 4;
    localparam int DEF_DATA_W = 8;
    localparam int GLYPH_SIZE = DEF_SPR_W * DEF_SPR_H;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // Constant multiply as a sum of shifted copies; k is always an elaboration constant.
    function automatic logic [31:0] shift_add_mul(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/sprite_xy_counter.sv
// rtl/sprite_xy_counter.sv - row-major x/y position inside one glyph.
module sprite_xy_counter #(
    parameter int SPR_W = 5,
    parameter int SPR_H = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clear,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       last
);

    logic [2:0] r_x;
    logic [2:0] r_y;
    logic       w_x_end;
    logic       w_y_end;

    assign w_x_end = (r_x == 3'(SPR_W - 1));
    assign w_y_end = (r_y == 3'(SPR_H - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (inc) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? 3'd0 : r_y + 3'd1;
            end else begin
                r_x <= r_x + 3'd1;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = w_x_end && w_y_end;

endmodule

// File: rtl/sprite_ram_writer.sv
// rtl/sprite_ram_writer.sv - turns a row-major pixel stream into sprite RAM writes for one glyph.
module sprite_ram_writer
    import sprite_pkg::*;
#(
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int GLYPHS = DEF_GLYPHS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        glyph,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        x_out,
    output logic [2:0]        y_out,
    output logic              busy,
    output logic              done
);

    localparam int SIZE = SPR_W * SPR_H;

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [2:0]        r_x_out;
    logic [2:0]        r_y_out;
    logic [31:0]       w_slot;
    logic [ADDR_W-1:0] w_base;
    logic              w_start;
    logic              w_accept;
    logic [2:0]        w_x;
    logic [2:0]        w_y;
    logic              w_last;

    assign w_slot   = 32'(glyph) % 32'(GLYPHS);
    assign w_base   = ADDR_W'(shift_add_mul(w_slot, 32'(SIZE)));
    assign w_start  = (r_state == IDLE) && start;
    assign w_accept = (r_state == LOAD) && in_valid;

    sprite_xy_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_xy (
        .clk   (clk),
        .reset (reset),
        .inc   (w_accept),
        .clear (w_start),
        .x     (w_x),
        .y     (w_y),
        .last  (w_last)
    );

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // Abort still lets a coincident pixel through; it only decides the next state.
                if (abort)                 w_next = IDLE;
                else if (in_valid && w_last) w_next = FLUSH;
            end
            FLUSH: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_x_out   <= '0;
            r_y_out   <= '0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_accept;
            if (w_start)       r_ptr <= w_base;
            else if (w_accept) r_ptr <= r_ptr + ADDR_W'(1);
            if (w_accept) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= in_data;
                r_x_out   <= w_x;
                r_y_out   <= w_y;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign x_out   = r_x_out;
    assign y_out   = r_y_out;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// tb/tb_sprite_ram_writer.sv - scoreboard bench for sprite_ram_writer.
module tb_sprite_ram_writer;

    localparam int W = 5;
    localparam int H = 5;
    localparam int NG = 4;
    localparam int AMOD = 128;

    typedef struct {
        int         cyc;
        logic [6:0] addr;
        logic [7:0] data;
        logic [2:0] x;
        logic [2:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] glyph = 2'd0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] x_out;
    logic [2:0] y_out;
    logic       busy;
    logic       done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    bit   rst_seen = 1'b1;
    exp_t q[$];
    logic [6:0] h_addr = '0;
    logic [7:0] h_data = '0;

    sprite_ram_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .glyph    (glyph),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .x_out    (x_out),
        .y_out    (y_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_seen = reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expectation, in its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            h_addr = '0;
            h_data = '0;
        end else if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_write", 32'(wr_addr), 32'hffff_ffff);
            end else begin
                e = q.pop_front();
                check("write_cycle", 32'(cyc), 32'(e.cyc));
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("x_out", 32'(x_out), 32'(e.x));
                check("y_out", 32'(y_out), 32'(e.y));
                h_addr = e.addr;
                h_data = e.data;
            end
        end else begin
            check("hold_addr", 32'(wr_addr), 32'(h_addr));
            check("hold_data", 32'(wr_data), 32'(h_data));
        end
        if (done === 1'b1) done_seen++;
    end

    // mode 0: back-to-back, 1: valid pattern 1,0,0,1, 2: random valid
    task automatic load(input int g, input int mode, input bit seq_data,
                        input int abort_after, input int reset_after, input int ign_at);
        int   k;
        int   t;
        int   base;
        logic v;
        exp_t e;
        base = (g % NG) * W * H;
        @(posedge clk); #1;
        start = 1'b1;
        glyph = 2'(g);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        t = 0;
        while (k < W * H) begin
            if (t > 2000) begin
                check("load_timeout", 32'(k), 32'(W * H));
                in_valid = 1'b0;
                return;
            end
            check("in_ready_load", 32'(in_ready), 32'd1);
            case (mode)
                0:       v = 1'b1;
                1:       v = ((t % 4) == 0) || ((t % 4) == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = seq_data ? 8'(k) : 8'($urandom);
            start    = (t == ign_at);
            if (t == ign_at) glyph = 2'd1;
            abort    = (abort_after >= 0) && (k == abort_after);
            if (v) begin
                e.cyc  = cyc + 1;
                e.addr = 7'((base + k) % AMOD);
                e.data = in_data;
                e.x    = 3'(k % W);
                e.y    = 3'(k / W);
                q.push_back(e);
                k++;
            end
            t++;
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin
                abort    = 1'b0;
                in_valid = 1'b0;
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                return;
            end
            if (reset_after >= 0 && k == reset_after) begin
                in_valid = 1'b0;
                reset    = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check("rst_mid_wr_en", 32'(wr_en), 32'd0);
                check("rst_mid_addr", 32'(wr_addr), 32'd0);
                check("rst_mid_data", 32'(wr_data), 32'd0);
                check("rst_mid_xy", 32'({x_out, y_out}), 32'd0);
                check("rst_mid_flags", 32'({in_ready, busy, done}), 32'd0);
                return;
            end
        end
        in_valid = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_done", 32'(done), 32'd0);
        done_exp++;
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("after_done", 32'(done), 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_y_out", 32'(y_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        load(0, 0, 1'b1, -1, -1, -1);
        load(3, 0, 1'b0, -1, -1, -1);
        load(1, 1, 1'b0, -1, -1, -1);
        load(2, 0, 1'b0, 7, -1, -1);
        load(2, 0, 1'b0, -1, -1, -1);
        load(0, 0, 1'b0, -1, 10, -1);
        load(0, 0, 1'b0, -1, -1, -1);
        load(0, 0, 1'b0, -1, -1, 5);
        for (int i = 0; i < 4; i++) begin
            load(int'($urandom_range(0, 3)), 2, 1'b0, -1, -1, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(done_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
